// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - programmable step sequencer (optional one-shot mode via SEQ_ONESHOT_EN)
module step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int FREQ_W    = 24,
    parameter int TEMPO_W   = 16,
    localparam int IDX_W    = $clog2(NUM_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo_div,
    input  logic [TEMPO_W-1:0] gate_len,
    input  logic [IDX_W-1:0]   last_step,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [FREQ_W-1:0]  wr_data,
`ifdef SEQ_ONESHOT_EN
    input  logic               oneshot,
    output logic               done,
`endif
    output logic [FREQ_W-1:0]  freq_out,
    output logic               gate_out,
    output logic [IDX_W-1:0]   step_idx,
    output logic               step_pulse,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t             state, state_nx;
    logic [FREQ_W-1:0]  pattern_mem [NUM_STEPS];
    logic [TEMPO_W-1:0] tick, tick_nx;
    logic [FREQ_W-1:0]  freq_nx;
    logic               gate_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic               pulse_nx;
    logic               busy_nx;
    logic               done_nx;

    logic               boundary;
    logic               wrap;
    logic [IDX_W-1:0]   load_idx;
    logic [FREQ_W-1:0]  load_word;
    logic [TEMPO_W:0]   tick_inc;
    logic               start_ok;
    logic               oneshot_end;

    assign boundary  = (tick == tempo_div);
    // An index beyond a freshly shortened pattern also wraps to step 0
    assign wrap      = (step_idx >= last_step);
    assign load_idx  = wrap ? '0 : step_idx + 1'b1;
    assign load_word = pattern_mem[load_idx];
    assign tick_inc  = {1'b0, tick} + 1'b1;

`ifdef SEQ_ONESHOT_EN
    logic finished;
    assign start_ok    = ~finished;
    assign oneshot_end = oneshot & wrap;

    // Latch completion of a one-shot pass until run is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finished <= 1'b0;
        end else if (!run) begin
            finished <= 1'b0;
        end else if (state == PLAY && boundary && oneshot_end) begin
            finished <= 1'b1;
        end
    end
`else
    assign start_ok    = 1'b1;
    assign oneshot_end = 1'b0;
`endif

    // Pattern table; a load on the same edge as a write reads the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pattern_mem[i] <= '0;
            end
        end else if (wr_en) begin
            pattern_mem[wr_addr] <= wr_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            freq_out   <= '0;
            gate_out   <= 1'b0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
`ifdef SEQ_ONESHOT_EN
            done       <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            tick       <= tick_nx;
            freq_out   <= freq_nx;
            gate_out   <= gate_nx;
            step_idx   <= idx_nx;
            step_pulse <= pulse_nx;
            busy       <= busy_nx;
`ifdef SEQ_ONESHOT_EN
            done       <= done_nx;
`endif
        end
    end

    // Next-state: start on run, stop on run low or end of a one-shot pass
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (run && start_ok) state_nx = PLAY;
            PLAY: begin
                if (!run) begin
                    state_nx = IDLE;
                end else if (boundary && oneshot_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output next values: step loads, gate timing, stop handling
    always_comb begin
        tick_nx  = tick;
        freq_nx  = freq_out;
        gate_nx  = gate_out;
        idx_nx   = step_idx;
        pulse_nx = 1'b0;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (run && start_ok) begin
                    tick_nx  = '0;
                    idx_nx   = '0;
                    freq_nx  = pattern_mem[0];
                    gate_nx  = (pattern_mem[0] != '0) && (gate_len != '0);
                    pulse_nx = 1'b1;
                    busy_nx  = 1'b1;
                end else begin
                    gate_nx = 1'b0;
                    busy_nx = 1'b0;
                end
            end
            PLAY: begin
                if (!run) begin
                    gate_nx = 1'b0;
                    busy_nx = 1'b0;
                end else if (boundary) begin
                    tick_nx = '0;
                    if (oneshot_end) begin
                        gate_nx = 1'b0;
                        busy_nx = 1'b0;
                        done_nx = 1'b1;
                    end else begin
                        idx_nx   = load_idx;
                        freq_nx  = load_word;
                        gate_nx  = (load_word != '0) && (gate_len != '0);
                        pulse_nx = 1'b1;
                    end
                end else begin
                    tick_nx = tick_inc[TEMPO_W-1:0];
                    // Gate ends as the tick count reaches gate_len; legato if never reached
                    if (tick_inc == {1'b0, gate_len}) gate_nx = 1'b0;
                end
            end
            default: begin
                gate_nx = 1'b0;
                busy_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - randomized and directed bench for step_sequencer
module tb_step_sequencer;
    localparam int NUM_STEPS = 8;
    localparam int FREQ_W    = 24;
    localparam int TEMPO_W   = 16;
    localparam int IW        = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic [TEMPO_W-1:0] tempo_div;
    logic [TEMPO_W-1:0] gate_len;
    logic [IW-1:0]      last_step;
    logic               wr_en;
    logic [IW-1:0]      wr_addr;
    logic [FREQ_W-1:0]  wr_data;
    logic [FREQ_W-1:0]  freq_out;
    logic               gate_out;
    logic [IW-1:0]      step_idx;
    logic               step_pulse;
    logic               busy;
    logic               oneshot = 1'b0;
    logic               done_sig;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    step_sequencer #(.NUM_STEPS(NUM_STEPS), .FREQ_W(FREQ_W), .TEMPO_W(TEMPO_W)) dut (
        .clk(clk), .rst(rst), .run(run), .tempo_div(tempo_div), .gate_len(gate_len),
        .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SEQ_ONESHOT_EN
        .oneshot(oneshot), .done(done_sig),
`endif
        .freq_out(freq_out), .gate_out(gate_out), .step_idx(step_idx),
        .step_pulse(step_pulse), .busy(busy)
    );
`ifndef SEQ_ONESHOT_EN
    assign done_sig = 1'b0;
`endif

    // Reference model: pattern words, play flag and clocks elapsed in current step
    logic [FREQ_W-1:0] m_tab [NUM_STEPS];
    bit m_play, m_gate, m_pulse, m_busy, m_done, m_fin;
    int m_idx, m_elapsed;
    logic [FREQ_W-1:0] m_freq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_STEPS; i++) m_tab[i] = '0;
        m_play = 0; m_gate = 0; m_pulse = 0; m_busy = 0; m_done = 0; m_fin = 0;
        m_idx = 0; m_elapsed = 0; m_freq = '0;
    endtask

    task automatic model_load(input int i);
        m_idx     = i;
        m_freq    = m_tab[i];
        m_gate    = (m_tab[i] != 0) && (gate_len != 0);
        m_pulse   = 1;
        m_busy    = 1;
        m_elapsed = 0;
    endtask

    task automatic model_clock();
        bit wrap;
        m_pulse = 0;
        m_done  = 0;
        if (!m_play) begin
            if (!run) m_fin = 0;
            else if (!m_fin) begin
                m_play = 1;
                model_load(0);
            end
        end else if (!run) begin
            m_play = 0; m_gate = 0; m_busy = 0;
        end else if (m_elapsed == int'(tempo_div)) begin
            wrap = (m_idx >= int'(last_step));
            if (oneshot && wrap) begin
                m_play = 0; m_gate = 0; m_busy = 0; m_done = 1; m_fin = 1;
            end else begin
                model_load(wrap ? 0 : m_idx + 1);
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == int'(gate_len)) m_gate = 0;
        end
        if (wr_en) m_tab[wr_addr] = wr_data;
    endtask

    task automatic compare_all();
        check("freq_out", 32'(freq_out), 32'(m_freq));
        check("gate_out", 32'(gate_out), 32'(m_gate));
        check("step_idx", 32'(step_idx), 32'(m_idx));
        check("step_pulse", 32'(step_pulse), 32'(m_pulse));
        check("busy", 32'(busy), 32'(m_busy));
`ifdef SEQ_ONESHOT_EN
        check("done", 32'(done_sig), 32'(m_done));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    logic [FREQ_W-1:0] seq [$];
    logic [FREQ_W-1:0] exp_seq [5];
    int pulses, dones, gates;
    bit hit;

    initial begin
        rst = 1; run = 0; tempo_div = '0; gate_len = '0; last_step = '0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        model_reset();
        #12;
        compare_all();
        rst = 0;

        // Load the basic pattern while idle
        exp_seq[0] = 24'h001000; exp_seq[1] = 24'h002000; exp_seq[2] = 24'h000000;
        exp_seq[3] = 24'h004000; exp_seq[4] = 24'h001000;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = IW'(i); wr_data = exp_seq[i];
            cycle();
        end
        wr_en = 0;
        last_step = 3; tempo_div = 9; gate_len = 5; run = 1;
        gates = 0;
        for (int c = 0; c < 45; c++) begin
            cycle();
            if (step_pulse) seq.push_back(freq_out);
            if (gate_out) gates++;
        end
        check("pulse_count", 32'(seq.size()), 32'd5);
        for (int k = 0; k < 5; k++) check("freq_seq", 32'(seq[k]), 32'(exp_seq[k]));
        check("gate_clocks", 32'(gates), 32'd20);

        // Legato across a boundary
        run = 0; cycle();
        gate_len = 20; run = 1;
        for (int c = 0; c < 25; c++) cycle();

        // Stop mid-step 1, then restart
        run = 0; cycle();
        gate_len = 5; run = 1;
        for (int c = 0; c < 14; c++) cycle();
        run = 0; cycle();
        check("stop_gate", 32'(gate_out), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_freq", 32'(freq_out), 32'h002000);
        run = 1; cycle();
        check("restart_idx", 32'(step_idx), 32'd0);
        check("restart_freq", 32'(freq_out), 32'h001000);

        // Write step 1 on the same edge that loads step 1
        hit = 0;
        for (int c = 0; c < 30 && !hit; c++) begin
            if (m_play && m_idx == 0 && m_elapsed == int'(tempo_div)) begin
                wr_en = 1; wr_addr = 1; wr_data = 24'h00ABCD;
                cycle();
                wr_en = 0;
                hit = 1;
                check("same_edge_old", 32'(freq_out), 32'h002000);
            end else begin
                cycle();
            end
        end
        check("same_edge_found", 32'(hit), 32'd1);
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            cycle();
            if (step_pulse && step_idx == 1) begin
                hit = 1;
                check("next_pass_new", 32'(freq_out), 32'h00ABCD);
            end
        end
        check("next_pass_found", 32'(hit), 32'd1);

        // Asynchronous reset during play
        for (int c = 0; c < 7; c++) cycle();
        rst = 1;
        #2;
        check("rst_freq", 32'(freq_out), 32'd0);
        check("rst_gate", 32'(gate_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(step_idx), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            cycle();
            if (step_pulse) pulses++;
        end
        check("rest_pulses", 32'(pulses), 32'd3);

        // Randomized play
        for (int c = 0; c < 2500; c++) begin
            run = ($urandom_range(0, 99) < 96);
            if (!m_play && $urandom_range(0, 3) == 0) tempo_div = TEMPO_W'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) gate_len = TEMPO_W'($urandom_range(0, 9));
            if ($urandom_range(0, 29) == 0) last_step = IW'($urandom_range(0, NUM_STEPS - 1));
            wr_en   = ($urandom_range(0, 9) < 3);
            wr_addr = IW'($urandom_range(0, NUM_STEPS - 1));
            wr_data = ($urandom_range(0, 3) == 0) ? '0 : FREQ_W'($urandom);
            cycle();
        end
        wr_en = 0;

`ifdef SEQ_ONESHOT_EN
        // One-shot pass: four steps then done, no further steps while run held
        run = 0; cycle();
        oneshot = 1; last_step = 3; tempo_div = 9; gate_len = 5; run = 1;
        pulses = 0; dones = 0;
        for (int c = 0; c < 80; c++) begin
            cycle();
            if (step_pulse) pulses++;
            if (done_sig) dones++;
        end
        check("oneshot_pulses", 32'(pulses), 32'd4);
        check("oneshot_done", 32'(dones), 32'd1);
        check("oneshot_busy", 32'(busy), 32'd0);
        run = 0; cycle();
        run = 1; cycle();
        check("oneshot_restart", 32'(busy), 32'd1);
        oneshot = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Pattern sequencer that drives the oscillator datapath.
- Steps through a small programmable table of 24-bit frequency words at a programmable tempo.
- Presents the current frequency word to the phase accumulator and generates a timed gate.
- Sits between the I2C register bank and the phase accumulator / gate logic. Its gate is ORed with the hardware/software gate outside this block.

Parameters:
- NUM_STEPS, 8: pattern length capacity; power of two, 2..16.
- FREQ_W, 24: frequency word width.
- TEMPO_W, 16: width of the step-period and gate-length counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- run  in  1  level; 1 = play, 0 = stop
- tempo_div  in  TEMPO_W  step period is tempo_div+1 clocks
- gate_len  in  TEMPO_W  gate-high clocks per step
- last_step  in  log2(NUM_STEPS)  index of final step before wrap
- wr_en  in  1  table write strobe
- wr_addr  in  log2(NUM_STEPS)  table write address
- wr_data  in  FREQ_W  frequency word; 0 = rest
- freq_out  out  FREQ_W  current frequency word
- gate_out  out  1  sequencer gate
- step_idx  out  log2(NUM_STEPS)  current step
- step_pulse  out  1  one-cycle strobe on each step load
- busy  out  1  high while not IDLE

Behaviour:
- Reset values: all table entries 0, freq_out=0, gate_out=0, step_idx=0, step_pulse=0, busy=0, state IDLE, tick counter 0.
- States: IDLE, PLAY. All outputs are registered.
- IDLE:
  - run sampled 1 at edge N → at edge N+1: step_idx=0, freq_out=table[0], step_pulse=1, busy=1, tick=0, state PLAY.
  - gate_out=1 at N+1 iff table[0]!=0 and gate_len!=0.
- PLAY:
  - tick increments every clock.
  - gate_out drops to 0 on the clock where tick reaches gate_len.
  - If gate_len > tempo_div, gate stays high through the step boundary (legato). It is re-evaluated at the next load: a rest drops it.
  - When tick==tempo_div: tick←0, step_idx←(step_idx==last_step)?0:step_idx+1, load freq_out/gate from the new index, step_pulse=1 for that cycle.
  - Rest step (word 0): freq_out=0, gate_out=0 for the whole step.
- run=0 in PLAY:
  - Next edge → IDLE, gate_out=0, busy=0.
  - freq_out and step_idx hold their last value.
  - Restart always begins at step 0.
- last_step changed mid-play:
  - Takes effect at the next boundary.
  - If step_idx > last_step at a boundary, wrap to 0.
- tempo_div=0: a new step loads every clock; the gate rule still applies.
- Table writes:
  - Accepted in any state, one per clock.
  - A write to the address being loaded on the same edge: the load sees the old value. The new value is used on the next visit.
- tempo_div / gate_len changed mid-step: compared live; no latching.
- rst mid-play: immediate return to reset values, including the table.

Optional Feature:
- Macro SEQ_ONESHOT_EN.
- Defined:
  - Adds input oneshot (1 bit) and output done (1 bit, reset 0).
  - With oneshot=1, the boundary after last_step returns to IDLE instead of wrapping: gate_out=0, busy=0, done=1 for one cycle.
  - run must go low then high to restart.
  - With oneshot=0, behaviour matches the undefined case.
- Undefined: the ports are absent; the sequence always loops.

Test Plan:
- Setup: table=[0x001000,0x002000,0,0x004000], last_step=3, tempo_div=9, gate_len=5, run 0→1 → step_pulse every 10 clocks; freq_out sequence 0x001000,0x002000,0,0x004000,0x001000. gate_out high 5 clocks per non-rest step and low all of step 2.
- gate_len=20, tempo_div=9, steps 0–1 non-zero → gate_out continuous across the boundary 0→1; drops at step 2 (rest).
- run deasserted mid-step 1 → next clock gate_out=0, busy=0, freq_out holds 0x002000. Re-assert run → step_idx=0, freq_out=0x001000 one clock later.
- Write table[1]=0x00ABCD on the same clock step 1 loads → freq_out=0x002000 on this pass, 0x00ABCD on the next pass.
- Assert rst for 1 cycle during PLAY → asynchronous clear of all outputs. After rst is released, run=1 plays rests (table cleared): gate_out stays 0, step_pulse continues.
- SEQ_ONESHOT_EN with oneshot=1, last_step=3, tempo_div=9 → exactly 4 step_pulses, then done=1 for one cycle, busy=0, no further steps while run stays 1.
